alu_result_buffer: RTL

ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

---
 rtl/alu_result_buffer.sv | 117 +++++++++++
 1 files changed

// File: rtl/alu_result_buffer.sv
// Two-entry in-order skid buffer between the ALU and the memory stage.
// The head register drives out_* and the forwarding tap; the skid register only absorbs backpressure.
module alu_result_buffer #(
   parameter int WIDTH = 32,
   parameter int RD_W  = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_result,
   input  logic             in_zero,
   input  logic [RD_W-1:0]  in_rd,
   input  logic             in_wb_en,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
   output logic [RD_W-1:0]  out_rd,
   output logic             out_wb_en,
   output logic             fwd_valid,
   output logic [RD_W-1:0]  fwd_rd,
   output logic [WIDTH-1:0] fwd_data,
   output logic [1:0]       occupancy
);

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

   typedef struct packed {
      logic [WIDTH-1:0] result;
      logic             zero;
      logic [RD_W-1:0]  rd;
      logic             wb_en;
   } entry_t;

   state_t state_q, state_d;
   entry_t head_q, skid_q, in_ent;
   logic   in_xfer, out_xfer;
   logic   load_head, load_skid, move_skid;

   assign in_ent   = {in_result, in_zero, in_rd, in_wb_en};
   // in_ready comes from state only, so it never chains back through out_ready.
   assign in_ready  = (state_q != TWO) && !rst;
   assign out_valid = (state_q != EMPTY);
   assign in_xfer   = in_valid && in_ready;
   assign out_xfer  = out_valid && out_ready;

   assign out_result = head_q.result;
   assign out_zero   = head_q.zero;
   assign out_rd     = head_q.rd;
   assign out_wb_en  = head_q.wb_en;

   assign fwd_valid = out_valid && head_q.wb_en && (head_q.rd != '0);
   assign fwd_rd    = head_q.rd;
   assign fwd_data  = head_q.result;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= EMPTY;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      load_head = 1'b0;
      load_skid = 1'b0;
      move_skid = 1'b0;
      occupancy = 2'd0;
      case (state_q)
         EMPTY: begin
            occupancy = 2'd0;
            if (in_xfer) begin
               load_head = 1'b1;
               state_d   = ONE;
            end
         end
         ONE: begin
            occupancy = 2'd1;
            if (in_xfer && out_xfer) begin
               load_head = 1'b1;
            end else if (in_xfer) begin
               load_skid = 1'b1;
               state_d   = TWO;
            end else if (out_xfer) begin
               state_d   = EMPTY;
            end
         end
         TWO: begin
            occupancy = 2'd2;
            if (out_xfer) begin
               move_skid = 1'b1;
               state_d   = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
      // Flush drops valids only; data registers keep their contents.
      if (flush) begin
         state_d   = EMPTY;
         load_head = 1'b0;
         load_skid = 1'b0;
         move_skid = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_head)      head_q <= in_ent;
         else if (move_skid) head_q <= skid_q;
         if (load_skid)      skid_q <= in_ent;
      end
   end

endmodule
